// File: rtl/chmod_quarter_wave_dds_if.sv
// Control/sample bundle between the TX modulator and its quadrature DDS.
interface chmod_quarter_wave_dds_if #(
  parameter int PHASE_WIDTH = 12,
  parameter int OUT_WIDTH   = 18
);
  logic [PHASE_WIDTH-1:0]      i_phase_inc;
  logic                        i_phase_inc_valid;
  logic                        i_ready;
  logic signed [OUT_WIDTH-1:0] o_cosine_data;
  logic signed [OUT_WIDTH-1:0] o_sine_data;
  logic                        o_valid;

  modport master (
    output i_phase_inc, i_phase_inc_valid, i_ready,
    input  o_cosine_data, o_sine_data, o_valid
  );

  modport slave (
    input  i_phase_inc, i_phase_inc_valid, i_ready,
    output o_cosine_data, o_sine_data, o_valid
  );
endinterface

// File: rtl/chmod_quarter_wave_dds.sv
// Quarter-wave ROM DDS: phase accumulator -> ROM read -> sign fold, stalled by i_ready.
module chmod_quarter_wave_dds #(
  parameter int PHASE_WIDTH = 12,
  parameter int OUT_WIDTH   = 18,
  parameter int ADDR_WIDTH  = PHASE_WIDTH - 2
) (
  input logic                      i_clock,
  input logic                      i_reset_n,
  chmod_quarter_wave_dds_if.slave  bus
);
  localparam int  DEPTH = 1 << ADDR_WIDTH;
  localparam int  FS    = (1 << (OUT_WIDTH - 1)) - 1;
  localparam real PI    = 3.14159265358979323846;

  typedef logic [OUT_WIDTH-2:0] mag_t;

  // Taylor series keeps the table build to plain real arithmetic at elaboration.
  function automatic mag_t rom_entry(input int k);
    real x, term, sum;
    x    = 2.0 * PI * (real'(k) + 0.5) / real'(1 << PHASE_WIDTH);
    term = x;
    sum  = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return mag_t'($rtoi(sum * real'(FS) + 0.5));
  endfunction

  mag_t rom [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = rom_entry(k);
  end

  logic [PHASE_WIDTH-1:0] phase_inc;
  logic [PHASE_WIDTH-1:0] phase_acc;
  logic [1:0]             prime;
  logic [1:0]             s1_q;
  mag_t                   s1_sin_mag;
  mag_t                   s1_cos_mag;
  logic [OUT_WIDTH-1:0]   s2_cos;
  logic [OUT_WIDTH-1:0]   s2_sin;

  logic [1:0]            q;
  logic [ADDR_WIDTH-1:0] a;
  logic [ADDR_WIDTH-1:0] m;
  logic [OUT_WIDTH-1:0]  sin_ext;
  logic [OUT_WIDTH-1:0]  cos_ext;

  assign q       = phase_acc[PHASE_WIDTH-1 -: 2];
  assign a       = phase_acc[ADDR_WIDTH-1:0];
  assign m       = ~a;
  assign sin_ext = {1'b0, s1_sin_mag};
  assign cos_ext = {1'b0, s1_cos_mag};

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      phase_inc  <= '0;
      phase_acc  <= '0;
      prime      <= '0;
      s1_q       <= '0;
      s1_sin_mag <= '0;
      s1_cos_mag <= '0;
      s2_cos     <= '0;
      s2_sin     <= '0;
    end else begin
      // Increment load restarts the phase and priming even while stalled.
      if (bus.i_phase_inc_valid) begin
        phase_inc <= bus.i_phase_inc;
        phase_acc <= '0;
        prime     <= '0;
      end else if (bus.i_ready) begin
        phase_acc <= phase_acc + phase_inc;
        if (prime != 2'd2) prime <= prime + 2'd1;
      end
      if (bus.i_ready) begin
        // Odd quadrants swap which of a / ~a feeds sin vs cos.
        s1_q       <= q;
        s1_sin_mag <= q[0] ? rom[m] : rom[a];
        s1_cos_mag <= q[0] ? rom[a] : rom[m];
        s2_sin     <= s1_q[1]           ? -sin_ext : sin_ext;
        s2_cos     <= (s1_q[1] ^ s1_q[0]) ? -cos_ext : cos_ext;
      end
    end
  end

  assign bus.o_cosine_data = s2_cos;
  assign bus.o_sine_data   = s2_sin;
  assign bus.o_valid       = (prime == 2'd2);
endmodule
